// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial RAM port controller.
// Length codes follow the pipeline's load/store length field.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_XFER = 2'd1,
    MEM_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  localparam logic [1:0] MEM_LEN_BYTE = 2'b00;
  localparam logic [1:0] MEM_LEN_HALF = 2'b01;
  localparam logic [1:0] MEM_LEN_WORD = 2'b10;

  // The reserved code 2'b11 falls through to a full word.
  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      MEM_LEN_BYTE: len_to_n = 3'd1;
      MEM_LEN_HALF: len_to_n = 3'd2;
      default:      len_to_n = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_rd_extend.sv
// Sign/zero extension of an assembled little-endian read word by access size.
// Bytes above the access size may hold stale data and are always replaced.
module mem_rd_extend
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [2:0]        n,
  input  logic              sext,
  output logic [DATA_W-1:0] ext
);

  always_comb begin
    ext = word;
    case (n)
      3'd1:    ext = {{(DATA_W-8){sext & word[7]}}, word[7:0]};
      3'd2:    ext = {{(DATA_W-16){sext & word[15]}}, word[15:0]};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Arbiter/sequencer sharing one byte-wide RAM port between instruction fetch
// and the MEM stage; each access is split into byte cycles.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic              mem_sext_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [7:0]        ram_din_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  output logic              if_done_o,
  output logic [DATA_W-1:0] if_data_o,
  output logic              mem_done_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              stall_req_o
);

  state_t            state_reg, state_next;
  owner_t            owner_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [2:0]        n_reg;
  logic [2:0]        cnt_reg;
  logic              we_reg;
  logic              sext_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] asm_reg;
  logic [DATA_W-1:0] asm_next;
  logic [DATA_W-1:0] ext_word;
  logic [DATA_W-1:0] if_data_reg;
  logic [DATA_W-1:0] mem_data_reg;
  logic              if_done_reg;
  logic              mem_done_reg;
  logic              grant_mem;
  logic              grant_if;
  logic              last_beat;
  logic              addr_active;

  // Byte k of a read arrives while cnt == k+1; slot it into its lane.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W / 8; gi++) begin : g_asm
      assign asm_next[8*gi +: 8] = (cnt_reg == 3'(gi + 1)) ? ram_din_i : asm_reg[8*gi +: 8];
    end
  endgenerate

  mem_rd_extend #(.DATA_W(DATA_W)) u_extend (
    .word (asm_next),
    .n    (n_reg),
    .sext (sext_reg),
    .ext  (ext_word)
  );

  always_comb begin
    grant_mem  = mem_req_i & ((MEM_FIRST != 0) | ~if_req_i);
    grant_if   = if_req_i & ~grant_mem;
    // Reads need one extra cycle for the final byte to come back.
    last_beat  = we_reg ? (cnt_reg == n_reg - 3'd1) : (cnt_reg == n_reg);
    state_next = state_reg;
    case (state_reg)
      MEM_IDLE: if (grant_if | grant_mem) state_next = MEM_XFER;
      MEM_XFER: if (last_beat) state_next = MEM_DONE;
      MEM_DONE: state_next = MEM_IDLE;
      default:  state_next = MEM_IDLE;
    endcase
  end

  always_comb begin
    addr_active = (state_reg == MEM_XFER) && (cnt_reg < n_reg);
    ram_addr_o  = addr_active ? base_reg + ADDR_W'(cnt_reg) : '0;
    ram_wr_o    = addr_active & we_reg;
    ram_dout_o  = ram_wr_o ? wdata_reg[8*cnt_reg[1:0] +: 8] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= MEM_IDLE;
      owner_reg    <= OWN_IF;
      base_reg     <= '0;
      n_reg        <= 3'd0;
      cnt_reg      <= 3'd0;
      we_reg       <= 1'b0;
      sext_reg     <= 1'b0;
      wdata_reg    <= '0;
      asm_reg      <= '0;
      if_data_reg  <= '0;
      mem_data_reg <= '0;
      if_done_reg  <= 1'b0;
      mem_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      if_done_reg  <= 1'b0;
      mem_done_reg <= 1'b0;
      case (state_reg)
        MEM_IDLE: begin
          cnt_reg <= 3'd0;
          asm_reg <= '0;
          if (grant_mem) begin
            owner_reg <= OWN_MEM;
            base_reg  <= mem_addr_i;
            n_reg     <= len_to_n(mem_len_i);
            we_reg    <= mem_we_i;
            sext_reg  <= mem_sext_i;
            wdata_reg <= mem_data_i;
          end else if (grant_if) begin
            owner_reg <= OWN_IF;
            base_reg  <= if_addr_i;
            n_reg     <= 3'd4;
            we_reg    <= 1'b0;
            sext_reg  <= 1'b0;
            wdata_reg <= '0;
          end
        end
        MEM_XFER: begin
          cnt_reg <= cnt_reg + 3'd1;
          asm_reg <= asm_next;
          if (last_beat) begin
            cnt_reg <= 3'd0;
            if (owner_reg == OWN_MEM) begin
              mem_done_reg <= 1'b1;
              if (!we_reg) mem_data_reg <= ext_word;
            end else begin
              if_done_reg <= 1'b1;
              if_data_reg <= ext_word;
            end
          end
        end
        default: cnt_reg <= 3'd0;
      endcase
    end
  end

  assign if_done_o   = if_done_reg;
  assign mem_done_o  = mem_done_reg;
  assign if_data_o   = if_data_reg;
  assign mem_data_o  = mem_data_reg;
  assign stall_req_o = (if_req_i & ~if_done_o) | (mem_req_i & ~mem_done_o);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: vector table of single accesses plus
// arbitration and reset-abort sequences, against a 256-byte RAM model.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_len_i;
  logic        mem_sext_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [7:0]  ram_din_i;
  logic [31:0] ram_addr_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o;
  logic        if_done_o;
  logic [31:0] if_data_o;
  logic        mem_done_o;
  logic [31:0] mem_data_o;
  logic        stall_req_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_FIRST(1)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i),
    .mem_sext_i(mem_sext_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .ram_din_i(ram_din_i), .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o),
    .ram_dout_o(ram_dout_o), .if_done_o(if_done_o), .if_data_o(if_data_o),
    .mem_done_o(mem_done_o), .mem_data_o(mem_data_o), .stall_req_o(stall_req_o)
  );

  // RAM model: registered read, byte address aliased onto 256 bytes.
  logic [7:0] ram [0:255];
  logic       pl_we = 1'b0;
  logic [7:0] pl_addr = 8'h00;
  logic [7:0] pl_data = 8'h00;
  always @(posedge clk) begin
    ram_din_i <= ram[ram_addr_o[7:0]];
    if (ram_wr_o) ram[ram_addr_o[7:0]] <= ram_dout_o;
    if (pl_we) ram[pl_addr] <= pl_data;
  end

  logic [31:0] log_addr  [0:63];
  logic        log_wr    [0:63];
  logic [7:0]  log_dout  [0:63];
  logic        log_stall [0:63];

  typedef struct {
    logic        we;
    logic [1:0]  len;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rbytes;
    logic [31:0] exp_data;
    int          n;
    int          exp_done;
  } vec_t;

  vec_t vecs [0:9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic preload4(input logic [31:0] a, input logic [31:0] b);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      pl_we   = 1'b1;
      pl_addr = a[7:0] + 8'(j);
      pl_data = b[8*j +: 8];
    end
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Caller raises requests between edges; the next rising edge is E0.
  // Cycle k is sampled at the falling edge after Ek; each requester drops
  // its req just after the edge ending its done cycle.
  task automatic run_xfer(input int maxc, output int md, output int id);
    md = -1;
    id = -1;
    @(posedge clk);
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      log_addr[k]  = ram_addr_o;
      log_wr[k]    = ram_wr_o;
      log_dout[k]  = ram_dout_o;
      log_stall[k] = stall_req_o;
      if (mem_done_o) md = k;
      if (if_done_o) id = k;
      @(posedge clk);
      #1;
      if (md == k) mem_req_i = 1'b0;
      if (id == k) if_req_i = 1'b0;
      if (!mem_req_i && !if_req_i) break;
    end
    if (mem_req_i || if_req_i) begin
      checks++;
      failures++;
      $display("FAIL timeout: got req still pending expected done within %0d cycles", maxc);
      mem_req_i = 1'b0;
      if_req_i  = 1'b0;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int md, id;
    vec_t v;

    vecs[0] = '{1'b0, MEM_LEN_WORD, 1'b0, 32'h0000_0100, 32'h0,         32'h4433_2211, 32'h4433_2211, 4, 5};
    vecs[1] = '{1'b0, MEM_LEN_BYTE, 1'b1, 32'h0000_0020, 32'h0,         32'h0000_0080, 32'hFFFF_FF80, 1, 2};
    vecs[2] = '{1'b0, MEM_LEN_BYTE, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_0080, 32'h0000_0080, 1, 2};
    vecs[3] = '{1'b0, MEM_LEN_HALF, 1'b1, 32'h0000_0024, 32'h0,         32'hAAAA_8001, 32'hFFFF_8001, 2, 3};
    vecs[4] = '{1'b0, MEM_LEN_HALF, 1'b0, 32'h0000_0024, 32'h0,         32'hAAAA_8001, 32'h0000_8001, 2, 3};
    vecs[5] = '{1'b0, MEM_LEN_HALF, 1'b1, 32'h0000_0028, 32'h0,         32'hFFFF_1234, 32'h0000_1234, 2, 3};
    vecs[6] = '{1'b0, MEM_LEN_WORD, 1'b1, 32'hFFFF_FFFE, 32'h0,         32'hDDCC_BBAA, 32'hDDCC_BBAA, 4, 5};
    vecs[7] = '{1'b1, MEM_LEN_WORD, 1'b0, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0,         32'hDDCC_BBAA, 4, 4};
    vecs[8] = '{1'b1, MEM_LEN_BYTE, 1'b0, 32'h0000_0030, 32'h1234_565A, 32'h0,         32'hDDCC_BBAA, 1, 1};
    vecs[9] = '{1'b0, 2'b11,        1'b1, 32'h0000_0040, 32'h0,         32'h0403_0201, 32'h0403_0201, 4, 5};

    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_len_i = 2'b00; mem_sext_i = 1'b0;
    mem_addr_i = '0; mem_data_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ram_addr", ram_addr_o, 32'h0);
    check("reset_ram_wr", 32'(ram_wr_o), 32'h0);
    check("reset_ram_dout", 32'(ram_dout_o), 32'h0);
    check("reset_dones", {30'h0, if_done_o, mem_done_o}, 32'h0);
    check("reset_if_data", if_data_o, 32'h0);
    check("reset_mem_data", mem_data_o, 32'h0);
    check("reset_stall", 32'(stall_req_o), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      preload4(v.addr, v.rbytes);
      @(negedge clk);
      mem_we_i = v.we; mem_len_i = v.len; mem_sext_i = v.sext;
      mem_addr_i = v.addr; mem_data_i = v.wdata; mem_req_i = 1'b1;
      run_xfer(20, md, id);
      check($sformatf("v%0d_done_cycle", i), 32'(md), 32'(v.exp_done));
      check($sformatf("v%0d_mem_data", i), mem_data_o, v.exp_data);
      for (int k = 0; k < v.n; k++) begin
        check($sformatf("v%0d_addr%0d", i, k), log_addr[k], v.addr + 32'(k));
        check($sformatf("v%0d_wr%0d", i, k), 32'(log_wr[k]), 32'(v.we));
        if (v.we) begin
          check($sformatf("v%0d_dout%0d", i, k), 32'(log_dout[k]), 32'(v.wdata[8*k +: 8]));
          check($sformatf("v%0d_ram%0d", i, k), 32'(ram[v.addr[7:0] + 8'(k)]), 32'(v.wdata[8*k +: 8]));
        end
      end
      check($sformatf("v%0d_idle_addr", i), log_addr[v.n], 32'h0);
      check($sformatf("v%0d_idle_wr", i), 32'(log_wr[v.n]), 32'h0);
      if (v.we && v.n == 1)
        check($sformatf("v%0d_ram_untouched", i), 32'(ram[v.addr[7:0] + 8'd1]), 32'h0);
      @(negedge clk);
      check($sformatf("v%0d_stall_after", i), 32'(stall_req_o), 32'h0);
    end

    // Simultaneous fetch and byte store: MEM wins, fetch follows after DONE.
    preload4(32'h0, 32'h0403_0201);
    preload4(32'h10, 32'h0);
    @(negedge clk);
    if_addr_i = 32'h0; if_req_i = 1'b1;
    mem_we_i = 1'b1; mem_len_i = MEM_LEN_BYTE; mem_sext_i = 1'b0;
    mem_addr_i = 32'h10; mem_data_i = 32'h0000_0077; mem_req_i = 1'b1;
    run_xfer(40, md, id);
    check("arb_mem_done_cycle", 32'(md), 32'd1);
    check("arb_if_done_cycle", 32'(id), 32'd8);
    check("arb_store_addr", log_addr[0], 32'h10);
    check("arb_store_wr", 32'(log_wr[0]), 32'h1);
    for (int k = 0; k < 8; k++)
      check($sformatf("arb_stall%0d", k), 32'(log_stall[k]), 32'h1);
    for (int j = 0; j < 4; j++)
      check($sformatf("arb_fetch_addr%0d", j), log_addr[3 + j], 32'(j));
    check("arb_if_data", if_data_o, 32'h0403_0201);
    check("arb_ram_store", 32'(ram[8'h10]), 32'h77);

    // Reset in cycle 2 of a word store aborts it; bytes 0..2 stay written.
    preload4(32'h80, 32'h0);
    @(negedge clk);
    mem_we_i = 1'b1; mem_len_i = MEM_LEN_WORD; mem_sext_i = 1'b0;
    mem_addr_i = 32'h80; mem_data_i = 32'hCAFE_F00D; mem_req_i = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    check("rst_wr_cycle2", 32'(ram_wr_o), 32'h1);
    check("rst_addr_cycle2", ram_addr_o, 32'h82);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_req_i = 1'b0;
    @(negedge clk);
    check("rst_wr_after", 32'(ram_wr_o), 32'h0);
    check("rst_addr_after", ram_addr_o, 32'h0);
    md = 0;
    for (int k = 0; k < 4; k++) begin
      if (mem_done_o) md++;
      @(negedge clk);
    end
    check("rst_no_done", 32'(md), 32'h0);
    check("rst_ram_byte2", 32'(ram[8'h82]), 32'hFE);
    check("rst_ram_byte3", 32'(ram[8'h83]), 32'h00);
    preload4(32'h90, 32'h0000_007F);
    @(negedge clk);
    mem_we_i = 1'b0; mem_len_i = MEM_LEN_BYTE; mem_sext_i = 1'b1;
    mem_addr_i = 32'h90; mem_req_i = 1'b1;
    run_xfer(20, md, id);
    check("post_rst_done_cycle", 32'(md), 32'd2);
    check("post_rst_data", mem_data_o, 32'h0000_007F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
